// File: rtl/wb_regfile_writer.sv
// Write-back stage: selects the MEM/WB result and commits it to a 32x32 register
// file with bypassed read ports. A circular log records every committed value.
module wb_regfile_writer #(
    parameter int DATA_W    = 32,
    parameter int NREG      = 32,
    parameter int LOG_DEPTH = 16
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         RegWriteIn,
    input  logic [1:0]                   MemToRegIn,
    input  logic [DATA_W-1:0]            RDin,
    input  logic [DATA_W-1:0]            ALUResultIn,
    input  logic [DATA_W-1:0]            PCin,
    input  logic [$clog2(NREG)-1:0]      WriteRegisterIn,
    input  logic [$clog2(NREG)-1:0]      ReadRegister1,
    input  logic [$clog2(NREG)-1:0]      ReadRegister2,
    output logic [DATA_W-1:0]            ReadData1,
    output logic [DATA_W-1:0]            ReadData2,
    output logic [DATA_W-1:0]            WriteDataOut,
    input  logic [$clog2(LOG_DEPTH)-1:0] LogIndex,
    output logic [DATA_W-1:0]            LogData,
    output logic [$clog2(LOG_DEPTH):0]   LogCount,
    output logic                         LogWrapped
);

    localparam int AW = $clog2(NREG);
    localparam int LW = $clog2(LOG_DEPTH);

    logic              we;
    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] log_q  [LOG_DEPTH];
    logic [LW-1:0]     wp_q, wp_d;
    logic [LW:0]       count_q, count_d;
    logic              wrapped_q, wrapped_d;
    logic [LW-1:0]     logSlot;

    assign we = RegWriteIn && (WriteRegisterIn != '0);

    always_comb begin
        case (MemToRegIn)
            2'b01:   WriteDataOut = RDin;
            2'b10:   WriteDataOut = PCin + DATA_W'(4);
            default: WriteDataOut = ALUResultIn;
        endcase
    end

    // Same-cycle write is forwarded so decode sees the value being committed now.
    assign ReadData1 = (ReadRegister1 == AW'(0)) ? '0 :
                       (we && ReadRegister1 == WriteRegisterIn) ? WriteDataOut :
                       regs_q[ReadRegister1];
    assign ReadData2 = (ReadRegister2 == AW'(0)) ? '0 :
                       (we && ReadRegister2 == WriteRegisterIn) ? WriteDataOut :
                       regs_q[ReadRegister2];

    always_comb begin
        wp_d      = wp_q;
        count_d   = count_q;
        wrapped_d = wrapped_q;
        if (we) begin
            wp_d = wp_q + LW'(1);
            if (count_q == (LW+1)'(LOG_DEPTH))
                wrapped_d = 1'b1;
            else
                count_d = count_q + (LW+1)'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            for (int i = 0; i < NREG; i++)
                regs_q[i] <= '0;
            for (int i = 0; i < LOG_DEPTH; i++)
                log_q[i] <= '0;
            wp_q      <= '0;
            count_q   <= '0;
            wrapped_q <= 1'b0;
        end else begin
            if (we) begin
                regs_q[WriteRegisterIn] <= WriteDataOut;
                log_q[wp_q]             <= WriteDataOut;
            end
            wp_q      <= wp_d;
            count_q   <= count_d;
            wrapped_q <= wrapped_d;
        end
    end

    // Index 0 is the entry just behind the write pointer (newest).
    assign logSlot    = wp_q - LW'(1) - LogIndex;
    assign LogData    = ({1'b0, LogIndex} < count_q) ? log_q[logSlot] : '0;
    assign LogCount   = count_q;
    assign LogWrapped = wrapped_q;

endmodule

// File: tb/tb_wb_regfile_writer.sv
// Testbench for wb_regfile_writer: directed scenarios plus a randomised
// back-to-back run against a reference model, using an expected-value queue.
module tb_wb_regfile_writer;

    logic        clock = 1'b0;
    logic        resetN;
    logic        regWrite;
    logic [1:0]  memToReg;
    logic [31:0] rdIn, aluIn, pcIn;
    logic [4:0]  writeReg, readReg1, readReg2;
    logic [31:0] readData1, readData2, writeDataOut;
    logic [3:0]  logIndex;
    logic [31:0] logData;
    logic [4:0]  logCount;
    logic        logWrapped;

    int nChecks = 0;
    int nFails  = 0;
    logic [31:0] expQ[$];
    logic [31:0] exp;

    logic [31:0] mRegs [32];
    logic [31:0] mLog[$];
    int          mCount;
    logic        mWrapped;

    wb_regfile_writer dut (
        .Clk(clock),
        .Reset(resetN),
        .RegWriteIn(regWrite),
        .MemToRegIn(memToReg),
        .RDin(rdIn),
        .ALUResultIn(aluIn),
        .PCin(pcIn),
        .WriteRegisterIn(writeReg),
        .ReadRegister1(readReg1),
        .ReadRegister2(readReg2),
        .ReadData1(readData1),
        .ReadData2(readData2),
        .WriteDataOut(writeDataOut),
        .LogIndex(logIndex),
        .LogData(logData),
        .LogCount(logCount),
        .LogWrapped(logWrapped)
    );

    always #5 clock = ~clock;

    task automatic driveWrite(input logic we, input logic [1:0] sel,
                              input logic [31:0] rd, input logic [31:0] alu,
                              input logic [31:0] pc, input logic [4:0] wreg);
        regWrite = we;
        memToReg = sel;
        rdIn     = rd;
        aluIn    = alu;
        pcIn     = pc;
        writeReg = wreg;
    endtask

    task automatic doReset();
        @(negedge clock);
        resetN = 1'b0;
        regWrite = 1'b0;
        repeat (2) @(negedge clock);
        resetN = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clock);
        resetN = 1'b0;
        driveWrite(1'b0, 2'b00, 32'h0, 32'hCAFE, 32'h0, 5'd5);
        readReg1 = 5'd5;
        readReg2 = 5'd0;
        logIndex = 4'd0;
        repeat (2) @(negedge clock);
        #1;
        nChecks++;
        if (logCount !== 5'd0) begin
            nFails++; $display("[TB] FAIL reset_count: got %0d expected 0", logCount);
        end
        nChecks++;
        if (logWrapped !== 1'b0) begin
            nFails++; $display("[TB] FAIL reset_wrapped: got %b expected 0", logWrapped);
        end
        nChecks++;
        if (readData1 !== 32'h0) begin
            nFails++; $display("[TB] FAIL reset_reg5: got %h expected 0", readData1);
        end
        nChecks++;
        if (writeDataOut !== 32'hCAFE) begin
            nFails++; $display("[TB] FAIL reset_wd_follows: got %h expected cafe", writeDataOut);
        end
        resetN = 1'b1;
    endtask

    task automatic test_bypass();
        @(negedge clock);
        driveWrite(1'b1, 2'b00, 32'h0, 32'h1234, 32'h0, 5'd5);
        readReg1 = 5'd5;
        expQ.push_back(32'h1234);
        expQ.push_back(32'h1234);
        #1;
        exp = expQ.pop_front(); nChecks++;
        if (writeDataOut !== exp) begin
            nFails++; $display("[TB] FAIL bypass_wd: got %h expected %h", writeDataOut, exp);
        end
        exp = expQ.pop_front(); nChecks++;
        if (readData1 !== exp) begin
            nFails++; $display("[TB] FAIL bypass_rd1: got %h expected %h", readData1, exp);
        end
        @(negedge clock);
        regWrite = 1'b0;
        logIndex = 4'd0;
        expQ.push_back(32'h1234);
        expQ.push_back(32'h1234);
        #1;
        exp = expQ.pop_front(); nChecks++;
        if (readData1 !== exp) begin
            nFails++; $display("[TB] FAIL committed_rd1: got %h expected %h", readData1, exp);
        end
        nChecks++;
        if (logCount !== 5'd1) begin
            nFails++; $display("[TB] FAIL bypass_count: got %0d expected 1", logCount);
        end
        exp = expQ.pop_front(); nChecks++;
        if (logData !== exp) begin
            nFails++; $display("[TB] FAIL bypass_log0: got %h expected %h", logData, exp);
        end
    endtask

    task automatic test_reg0();
        @(negedge clock);
        driveWrite(1'b1, 2'b00, 32'h0, 32'hFFFF, 32'h0, 5'd0);
        readReg1 = 5'd0;
        #1;
        nChecks++;
        if (readData1 !== 32'h0) begin
            nFails++; $display("[TB] FAIL reg0_bypass: got %h expected 0", readData1);
        end
        @(negedge clock);
        regWrite = 1'b0;
        readReg1 = 5'd0;
        readReg2 = 5'd5;
        #1;
        nChecks++;
        if (readData1 !== 32'h0) begin
            nFails++; $display("[TB] FAIL reg0_read: got %h expected 0", readData1);
        end
        nChecks++;
        if (logCount !== 5'd1) begin
            nFails++; $display("[TB] FAIL reg0_count: got %0d expected 1", logCount);
        end
        nChecks++;
        if (readData2 !== 32'h1234) begin
            nFails++; $display("[TB] FAIL reg0_reg5: got %h expected 1234", readData2);
        end
    endtask

    task automatic test_select();
        logic [1:0]  sels [4] = '{2'b01, 2'b10, 2'b10, 2'b11};
        logic [31:0] rds  [4] = '{32'hA5A5A5A5, 32'h1, 32'h2, 32'h3};
        logic [31:0] alus [4] = '{32'h11, 32'h22, 32'h33, 32'h55};
        logic [31:0] pcs  [4] = '{32'h44, 32'hFFFFFFFC, 32'h100, 32'h66};
        logic [31:0] wants[4] = '{32'hA5A5A5A5, 32'h0, 32'h104, 32'h55};
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            driveWrite(1'b1, sels[i], rds[i], alus[i], pcs[i], 5'd6);
            expQ.push_back(wants[i]);
            expQ.push_back(wants[i]);
            #1;
            exp = expQ.pop_front(); nChecks++;
            if (writeDataOut !== exp) begin
                nFails++; $display("[TB] FAIL select%0d_wd: got %h expected %h", i, writeDataOut, exp);
            end
            @(negedge clock);
            regWrite = 1'b0;
            readReg2 = 5'd6;
            #1;
            exp = expQ.pop_front(); nChecks++;
            if (readData2 !== exp) begin
                nFails++; $display("[TB] FAIL select%0d_reg6: got %h expected %h", i, readData2, exp);
            end
        end
    endtask

    task automatic test_log_wrap();
        doReset();
        for (int v = 1; v <= 17; v++) begin
            @(negedge clock);
            if (v == 17) begin
                regWrite = 1'b0;
                #1;
                nChecks++;
                if (logCount !== 5'd16 || logWrapped !== 1'b0) begin
                    nFails++;
                    $display("[TB] FAIL wrap_full: got count %0d wrapped %b expected 16/0", logCount, logWrapped);
                end
            end
            driveWrite(1'b1, 2'b00, 32'h0, 32'(v), 32'h0, 5'(v % 31 + 1));
        end
        @(negedge clock);
        regWrite = 1'b0;
        logIndex = 4'd0;
        #1;
        nChecks++;
        if (logCount !== 5'd16) begin
            nFails++; $display("[TB] FAIL wrap_count: got %0d expected 16", logCount);
        end
        nChecks++;
        if (logWrapped !== 1'b1) begin
            nFails++; $display("[TB] FAIL wrap_flag: got %b expected 1", logWrapped);
        end
        for (int i = 0; i < 16; i++) begin
            logIndex = 4'(i);
            expQ.push_back(32'(17 - i));
            #1;
            exp = expQ.pop_front(); nChecks++;
            if (logData !== exp) begin
                nFails++; $display("[TB] FAIL wrap_log%0d: got %h expected %h", i, logData, exp);
            end
        end
    endtask

    task automatic test_reset_dominates();
        @(negedge clock);
        resetN = 1'b0;
        driveWrite(1'b1, 2'b00, 32'h0, 32'h77, 32'h0, 5'd7);
        @(negedge clock);
        resetN = 1'b1;
        regWrite = 1'b0;
        readReg1 = 5'd7;
        #1;
        nChecks++;
        if (readData1 !== 32'h0) begin
            nFails++; $display("[TB] FAIL resetdom_reg7: got %h expected 0", readData1);
        end
        nChecks++;
        if (logCount !== 5'd0 || logWrapped !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL resetdom_log: got count %0d wrapped %b expected 0/0", logCount, logWrapped);
        end
        @(negedge clock);
        driveWrite(1'b1, 2'b00, 32'h0, 32'h99, 32'h0, 5'd3);
        @(negedge clock);
        regWrite = 1'b0;
        logIndex = 4'd3;
        #1;
        nChecks++;
        if (logData !== 32'h0) begin
            nFails++; $display("[TB] FAIL resetdom_idx3: got %h expected 0", logData);
        end
        logIndex = 4'd0;
        #1;
        nChecks++;
        if (logData !== 32'h99) begin
            nFails++; $display("[TB] FAIL resetdom_idx0: got %h expected 99", logData);
        end
    endtask

    task automatic test_dual_bypass();
        @(negedge clock);
        driveWrite(1'b1, 2'b00, 32'h0, 32'hBEEF, 32'h0, 5'd10);
        @(negedge clock);
        driveWrite(1'b1, 2'b00, 32'h0, 32'hDEAD, 32'h0, 5'd9);
        readReg1 = 5'd9;
        readReg2 = 5'd9;
        #1;
        nChecks++;
        if (readData1 !== 32'hDEAD || readData2 !== 32'hDEAD) begin
            nFails++;
            $display("[TB] FAIL dual_same: got %h/%h expected dead/dead", readData1, readData2);
        end
        readReg2 = 5'd10;
        #1;
        nChecks++;
        if (readData2 !== 32'hBEEF) begin
            nFails++; $display("[TB] FAIL dual_other: got %h expected beef", readData2);
        end
        @(negedge clock);
        regWrite = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic        we;
        logic [1:0]  sel;
        logic [31:0] rd, alu, pc, wd;
        logic [4:0]  wreg;
        doReset();
        for (int r = 0; r < 32; r++) mRegs[r] = '0;
        mLog.delete();
        mCount = 0;
        mWrapped = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            we   = ($urandom_range(0, 3) != 0);
            sel  = 2'($urandom_range(0, 3));
            rd   = $urandom();
            alu  = $urandom();
            pc   = $urandom();
            wreg = 5'($urandom_range(0, 31));
            driveWrite(we, sel, rd, alu, pc, wreg);
            readReg1 = ($urandom_range(0, 1) != 0) ? wreg : 5'($urandom_range(0, 31));
            readReg2 = 5'($urandom_range(0, 31));
            case (sel)
                2'b01:   wd = rd;
                2'b10:   wd = pc + 32'd4;
                default: wd = alu;
            endcase
            expQ.push_back(wd);
            expQ.push_back((readReg1 == 0) ? 32'h0 :
                           (we && wreg != 0 && readReg1 == wreg) ? wd : mRegs[readReg1]);
            expQ.push_back((readReg2 == 0) ? 32'h0 :
                           (we && wreg != 0 && readReg2 == wreg) ? wd : mRegs[readReg2]);
            #1;
            exp = expQ.pop_front(); nChecks++;
            if (writeDataOut !== exp) begin
                nFails++; $display("[TB] FAIL b2b%0d_wd: got %h expected %h", c, writeDataOut, exp);
            end
            exp = expQ.pop_front(); nChecks++;
            if (readData1 !== exp) begin
                nFails++; $display("[TB] FAIL b2b%0d_rd1: got %h expected %h", c, readData1, exp);
            end
            exp = expQ.pop_front(); nChecks++;
            if (readData2 !== exp) begin
                nFails++; $display("[TB] FAIL b2b%0d_rd2: got %h expected %h", c, readData2, exp);
            end
            if (we && wreg != 0) begin
                mRegs[wreg] = wd;
                mLog.push_front(wd);
                if (mLog.size() > 16) void'(mLog.pop_back());
                if (mCount == 16) mWrapped = 1'b1;
                else mCount++;
            end
        end
        @(negedge clock);
        regWrite = 1'b0;
        #1;
        nChecks++;
        if (logCount !== 5'(mCount) || logWrapped !== mWrapped) begin
            nFails++;
            $display("[TB] FAIL b2b_logstate: got %0d/%b expected %0d/%b", logCount, logWrapped, mCount, mWrapped);
        end
        for (int i = 0; i < 16; i++) begin
            logIndex = 4'(i);
            expQ.push_back((i < mCount) ? mLog[i] : 32'h0);
            #1;
            exp = expQ.pop_front(); nChecks++;
            if (logData !== exp) begin
                nFails++; $display("[TB] FAIL b2b_log%0d: got %h expected %h", i, logData, exp);
            end
        end
    endtask

    initial begin
        resetN = 1'b0;
        driveWrite(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0);
        readReg1 = 5'd0;
        readReg2 = 5'd0;
        logIndex = 4'd0;
        test_reset();
        test_bypass();
        test_reg0();
        test_select();
        test_log_wrap();
        test_reset_dominates();
        test_dual_bypass();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
